toggle_counter: RTL and testbench

TOGGLE_COUNTER -- requirements
Module: toggle_counter

---
 rtl/toggle_counter_pkg.sv | 11 +
 rtl/toggle_counter_if.sv | 28 ++
 rtl/tff_cell.sv | 29 ++
 rtl/toggle_counter.sv | 84 ++++++++
 tb/tb_toggle_counter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/toggle_counter_pkg.sv
// Shared constants for the toggle_counter block.
// Build option: define TOGGLE_COUNTER_SATURATE_EN for saturate mode (default: wrap).
package toggle_counter_pkg;

    localparam int   DEFAULT_WIDTH = 4;

    // Counting direction as carried on the 'up' input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : toggle_counter_pkg

// File: rtl/toggle_counter_if.sv
// Control and status bundle for toggle_counter.
// The master drives enable/direction/load. The slave (the counter) returns the count and its flags.
interface toggle_counter_if
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             tc;
    logic             bound;

    modport master (
        output en, up, load, load_val,
        input  Q, Qb, tc, bound
    );

    modport slave (
        input  en, up, load, load_val,
        output Q, Qb, tc, bound
    );

endinterface : toggle_counter_if

// File: rtl/tff_cell.sv
// Single T flip-flop bit with a synchronous active-high reset.
// It provides true and complement outputs, and both are registered.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic i_t,
    output logic o_q,
    output logic o_qb
);

    logic r_q;
    logic r_qb;

    // Toggle both halves together so the complement can never drift from the true output
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_q  <= 1'b0;
            r_qb <= 1'b1;
        end else if (i_t) begin
            r_q  <= ~r_q;
            r_qb <= ~r_qb;
        end
    end

    assign o_q  = r_q;
    assign o_qb = r_qb;

endmodule : tff_cell

// File: rtl/toggle_counter.sv
// Up/down counter built from T flip-flops. It has a synchronous load, a terminal-count flag,
// and a one-cycle boundary flag.
// Build option: define TOGGLE_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MAX   = 2**WIDTH - 1
)(
    input  logic              clock,
    input  logic              reset,
    toggle_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_t;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic             r_bound;

    assign w_at_max  = (w_q == MAX_Q);
    assign w_at_zero = (w_q == ZERO_Q);

    // The terminal count follows the live direction input, so a direction change shows up immediately
    assign w_tc = ((bus.up == DIR_UP)   && w_at_max) ||
                  ((bus.up == DIR_DOWN) && w_at_zero);

    // Select the next count: load (clamped) beats a step, and with neither the count holds
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves w_q_next unassigned (no latch).
        w_q_next = w_q;
        if (bus.load) begin
            w_q_next = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
        end else if (bus.en) begin
            if (w_tc) begin
`ifdef TOGGLE_COUNTER_SATURATE_EN
                w_q_next = w_q;
`else
                w_q_next = (bus.up == DIR_UP) ? ZERO_Q : MAX_Q;
`endif
            end else if (bus.up == DIR_UP) begin
                w_q_next = w_q + ONE_Q;
            end else begin
                w_q_next = w_q - ONE_Q;
            end
        end
    end

    // Each bit toggles exactly where the current and next counts differ
    assign w_t = w_q ^ w_q_next;

    // One T flip-flop per count bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .i_t   (w_t[gi]),
            .o_q   (w_q[gi]),
            .o_qb  (w_qb[gi])
        );
    end

    // Flag a step taken at a bound for exactly one cycle; a load or an idle cycle clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bound <= 1'b0;
        end else begin
            r_bound <= !bus.load && bus.en && w_tc;
        end
    end

    assign bus.Q     = w_q;
    assign bus.Qb    = w_qb;
    assign bus.tc    = w_tc;
    assign bus.bound = r_bound;

endmodule : toggle_counter

// File: tb/tb_toggle_counter.sv
// Directed bench for toggle_counter at WIDTH=4, MAX=9.
// The driver pushes expected results into a scoreboard queue, and a monitor pops and compares them after each edge.
// Define TOGGLE_COUNTER_SATURATE_EN to check a saturate build.
module tb_toggle_counter;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] qb;
        logic             bound;
        logic             tc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    toggle_counter_if #(.WIDTH(WIDTH)) bus ();

    toggle_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the result expected after the next rising edge
    task automatic vec(input string name, input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                       input logic e, input logic u, input logic [WIDTH-1:0] eq, input logic eb);
        exp_t x;
        @(negedge clock);
        reset        = r;
        bus.load     = ld;
        bus.load_val = lv;
        bus.en       = e;
        bus.up       = u;
        x.name  = name;
        x.q     = eq;
        x.qb    = ~eq;
        x.bound = eb;
        x.tc    = (u && eq == 4'd9) || (!u && eq == 4'd0);
        sb.push_back(x);
    endtask

    // Monitor: compare the DUT against the oldest expectation just after each edge
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check({x.name, ".Q"},     16'(bus.Q),     16'(x.q));
                check({x.name, ".Qb"},    16'(bus.Qb),    16'(x.qb));
                check({x.name, ".bound"}, 16'(bus.bound), 16'(x.bound));
                check({x.name, ".tc"},    16'(bus.tc),    16'(x.tc));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic sat;
`ifdef TOGGLE_COUNTER_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        reset = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.up = 1'b1;

        vec("reset", 1, 0, 4'd0, 0, 1, 4'd0, 0);

        // Count up for 12 clocks: 1..9, then a wrap (or hold) with a bound pulse
        for (int i = 1; i <= 9; i++) vec($sformatf("up%0d", i), 0, 0, 4'd0, 1, 1, 4'(i), 0);
        vec("up10", 0, 0, 4'd0, 1, 1, sat ? 4'd9 : 4'd0, 1);
        vec("up11", 0, 0, 4'd0, 1, 1, sat ? 4'd9 : 4'd1, sat);
        vec("up12", 0, 0, 4'd0, 1, 1, sat ? 4'd9 : 4'd2, sat);

        // A load above MAX clamps; en on the same edge is ignored
        vec("load13", 0, 1, 4'd13, 1, 1, 4'd9, 0);

        // Step down from zero, then idle
        vec("load0",   0, 1, 4'd0, 0, 0, 4'd0, 0);
        vec("dn_from0", 0, 0, 4'd0, 1, 0, sat ? 4'd0 : 4'd9, 1);
        vec("idle",    0, 0, 4'd0, 0, 0, sat ? 4'd0 : 4'd9, 0);

        // Plain decrement
        vec("load3", 0, 1, 4'd3, 0, 0, 4'd3, 0);
        vec("dn2",   0, 0, 4'd0, 1, 0, 4'd2, 0);
        vec("dn1",   0, 0, 4'd0, 1, 0, 4'd1, 0);

        // Reset beats load, then counting resumes from zero
        vec("load5",     0, 1, 4'd5, 0, 1, 4'd5, 0);
        vec("rst_vs_ld", 1, 1, 4'd7, 1, 1, 4'd0, 0);
        vec("after_rst", 0, 0, 4'd0, 1, 1, 4'd1, 0);

        // Reverse the direction on every clock
        vec("load4", 0, 1, 4'd4, 0, 1, 4'd4, 0);
        vec("alt5a", 0, 0, 4'd0, 1, 1, 4'd5, 0);
        vec("alt4a", 0, 0, 4'd0, 1, 0, 4'd4, 0);
        vec("alt5b", 0, 0, 4'd0, 1, 1, 4'd5, 0);
        vec("alt4b", 0, 0, 4'd0, 1, 0, 4'd4, 0);

        // Load just above MAX, then step up past the top
        vec("load10", 0, 1, 4'd10, 0, 1, 4'd9, 0);
        vec("up_top", 0, 0, 4'd0, 1, 1, sat ? 4'd9 : 4'd0, 1);
        vec("idle2",  0, 0, 4'd0, 0, 1, sat ? 4'd9 : 4'd0, 0);

        @(negedge clock);
        bus.en = 1'b0; bus.load = 1'b0;
        @(negedge clock);
        check("drained", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_toggle_counter
